// File: rtl/shift_pattern_ctrl.sv
// Pattern sequencer for a chain of NUM_REGS 74hc595 registers driven through the serial shifter.
// Optional build macro READY_TIMEOUT_EN adds a sticky ready-wait timeout (o_error).
module shift_pattern_ctrl #(
  parameter int unsigned          NUM_REGS       = 1,
  parameter int unsigned          PERIOD         = 24'd10000000,
  parameter logic [8*NUM_REGS-1:0] INIT_PATTERN  = {NUM_REGS{8'h55}},
  parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run,
  input  logic [1:0]              i_mode,
  input  logic                    i_load,
  input  logic [8*NUM_REGS-1:0]   i_load_data,
  input  logic                    i_ready,
  output logic [8*NUM_REGS-1:0]   o_data,
  output logic                    o_enable,
  output logic                    o_busy,
  output logic [15:0]             o_frames,
  output logic                    o_error
);

  localparam int W  = 8 * NUM_REGS;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] STROBE     = 3'd1;
  localparam logic [2:0] GUARD      = 3'd2;
  localparam logic [2:0] WAIT_READY = 3'd3;
  localparam logic [2:0] WAIT_TICK  = 3'd4;
  localparam logic [2:0] UPDATE     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  pend_data_q, pend_data_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   frames_q, frames_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;

`ifdef READY_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic          error_q, error_d;
  logic [CW-1:0] to_q, to_d;
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    timer_d     = timer_q;
    frames_d    = frames_q;
`ifdef READY_TIMEOUT_EN
    error_d     = error_q;
    to_d        = '0;
`endif

    // Loads outside UPDATE: immediate when idle, otherwise deferred to the next UPDATE
    if (i_load && (state_q != UPDATE)) begin
      if (state_q == IDLE) begin
        data_d = i_load_data;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = i_load_data;
      end
    end

    case (state_q)
      IDLE:   if (i_run && !o_error) state_d = STROBE;
      STROBE: state_d = GUARD;
      GUARD:  state_d = WAIT_READY;
      WAIT_READY: begin
        if (i_ready) begin
          timer_d = TW'(PERIOD - 1);
          state_d = WAIT_TICK;
        end
`ifdef READY_TIMEOUT_EN
        else if (to_q == CW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      WAIT_TICK: begin
        if (timer_q == '0) state_d = UPDATE;
        else               timer_d = timer_q - 1'b1;
      end
      UPDATE: begin
        if (pend_q) begin
          data_d = pend_data_q;
        end else begin
          case (i_mode)
            2'd0:    data_d = ~data_q;
            2'd1:    data_d = {data_q[W-2:0], data_q[W-1]};
            2'd2:    data_d = data_q + W'(1);
            default: data_d = data_q;
          endcase
        end
        // A load landing in this very cycle becomes the pending word for the next frame
        pend_d = i_load;
        if (i_load) pend_data_d = i_load_data;
        frames_d = frames_q + 16'd1;
        state_d  = i_run ? STROBE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    enable_d = (state_d == STROBE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      data_q      <= INIT_PATTERN;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      timer_q     <= '0;
      frames_q    <= 16'd0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      timer_q     <= timer_d;
      frames_q    <= frames_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
    end
  end

`ifdef READY_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      error_q <= 1'b0;
      to_q    <= '0;
    end else begin
      error_q <= error_d;
      to_q    <= to_d;
    end
  end
`endif

  assign o_data   = data_q;
  assign o_enable = enable_q;
  assign o_busy   = busy_q;
  assign o_frames = frames_q;

endmodule
